// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, FSM states and the
// select/control codes driven to Extend, the ALU and the datapath muxes.
package riscv_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned IMMSRC_W = 3;

  localparam logic [OP_W-1:0] LW     = 7'b0000011;
  localparam logic [OP_W-1:0] SW     = 7'b0100011;
  localparam logic [OP_W-1:0] RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] LUI    = 7'b0110111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_JALRPC = 4'd12,
    S_LUI    = 4'd13
  } state_t;

  typedef enum logic [IMMSRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

  typedef enum logic [ALUCTL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [SEL_W-1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_t;

  typedef enum logic [SEL_W-1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } src_a_t;

  typedef enum logic [SEL_W-1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      LW, SW, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the instruction's funct fields onto
// the ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t               alu_op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  op5,
  input  logic                  funct7b5,
  output logic [ALUCTL_W-1:0]   alu_control_c
);

  always_comb begin
    alu_control_c = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control_c = ALU_ADD;
      ALUOP_SUB: alu_control_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi ignores it.
          3'b000:  alu_control_c = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_c = ALU_SLT;
          3'b110:  alu_control_c = ALU_OR;
          3'b111:  alu_control_c = ALU_AND;
          default: alu_control_c = ALU_ADD;
        endcase
      end
      default: alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences the shared ALU, memory
// port, register file and Extend block across the cycles of each instruction.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      op,
  input  logic [F3_W-1:0]      funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 adrSrc,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 regWrite,
  output logic [SEL_W-1:0]     resultSrc,
  output logic [SEL_W-1:0]     aluSrcA,
  output logic [SEL_W-1:0]     aluSrcB,
  output logic [ALUCTL_W-1:0]  aluControl,
  output logic [IMMSRC_W-1:0]  immSrc,
  output logic                 illegalOp
);

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;

  logic pc_write_c;
  logic mem_write_c;
  logic ir_write_c;
  logic reg_write_c;
  logic illegal_c;

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          LW, SW:  state_next = S_MEMADR;
          RTYPE:   state_next = S_EXER;
          ITYPE:   state_next = S_EXEI;
          BRANCH:  state_next = S_BRANCH;
          JAL:     state_next = S_JAL;
          JALR:    state_next = S_JALR;
          LUI:     state_next = S_LUI;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (op == SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = memReady ? S_FETCH : S_MEMWR;
      S_EXER:   state_next = S_ALUWB;
      S_EXEI:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JAL:    state_next = S_ALUWB;
      S_JALR:   state_next = S_JALRPC;
      S_JALRPC: state_next = S_ALUWB;
      S_LUI:    state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath control decode from the current state and IR fields.
  always_comb begin
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = RES_ALUOUT;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_RD2;
    immSrc      = IMM_I;
    alu_op      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALURESULT;
        ir_write_c = memReady;
        pc_write_c = memReady;
      end
      S_DECODE: begin
        // Branch target is formed here so BRANCH only needs the compare.
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_IMM;
        immSrc    = IMM_B;
        illegal_c = ~is_legal_op(op);
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        immSrc  = (op == SW) ? IMM_S : IMM_I;
      end
      S_MEMRD: adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc   = RES_MEMDATA;
        reg_write_c = 1'b1;
      end
      S_MEMWR: begin
        adrSrc      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXER: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXEI: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        immSrc  = IMM_I;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        resultSrc   = RES_ALUOUT;
        reg_write_c = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA    = SRCA_RD1;
        aluSrcB    = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        resultSrc  = RES_ALUOUT;
        pc_write_c = zero ^ funct3[0];
      end
      S_JAL: begin
        aluSrcA    = SRCA_OLDPC;
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALUOUT;
        immSrc     = IMM_J;
        pc_write_c = 1'b1;
      end
      S_JALR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        immSrc  = IMM_I;
      end
      S_JALRPC: begin
        aluSrcA    = SRCA_OLDPC;
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALUOUT;
        pc_write_c = 1'b1;
      end
      S_LUI: begin
        immSrc      = IMM_U;
        resultSrc   = RES_IMMEXT;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is held so nothing is written mid-abort.
  assign pcWrite   = pc_write_c  & ~rst;
  assign memWrite  = mem_write_c & ~rst;
  assign irWrite   = ir_write_c  & ~rst;
  assign regWrite  = reg_write_c & ~rst;
  assign illegalOp = illegal_c   & ~rst;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .op5           (op[5]),
    .funct7b5      (funct7b5),
    .alu_control_c (aluControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle and compares the full control word against hand-derived values.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic [2:0] immSrc;
  logic       illegalOp;

  int checks = 0;
  int errors = 0;

  logic [17:0] obs;
  logic [4:0]  en;

  logic [17:0] e_fetch;
  logic [17:0] e_fetch_wait;
  logic [17:0] e_decode;
  logic [17:0] e_aluwb;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .immSrc     (immSrc),
    .illegalOp  (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
                aluSrcA, aluSrcB, aluControl, immSrc, illegalOp};
  assign en  = {pcWrite, memWrite, irWrite, regWrite, illegalOp};

  // Expected control word in the same bit order as obs.
  function automatic logic [17:0] fe(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [2:0] imm,
                                     input logic ill);
    fe = {pc, adr, mw, ir, rw, rs, a, b, alu, imm, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance one clock.
  task automatic step(input string tag, input logic [17:0] exp);
    #2;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic itype_alu(input string tag, input logic [2:0] f3, input logic [2:0] alu);
    op = 7'b0010011; funct3 = f3; funct7b5 = 1'b0;
    step({tag, "_fetch"}, e_fetch);
    step({tag, "_decode"}, e_decode);
    step({tag, "_exei"}, fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,alu,3'b000,1'b0));
    step({tag, "_aluwb"}, e_aluwb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    e_fetch      = fe(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,3'b000,1'b0);
    e_fetch_wait = fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,3'b000,1'b0);
    e_decode     = fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b010,1'b0);
    e_aluwb      = fe(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0);

    rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    zero = 1'b0; memReady = 1'b1;

    // Reset: enables stay low even though FETCH would raise irWrite/pcWrite.
    #2;
    check("rst_en0", 32'(en), 32'd0);
    @(posedge clk); #1;
    check("rst_en1", 32'(en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FETCH waits on memReady.
    memReady = 1'b0;
    step("fetch_wait", e_fetch_wait);
    memReady = 1'b1;

    // lw, no wait states.
    step("lw_fetch", e_fetch);
    step("lw_decode", e_decode);
    step("lw_memadr", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b000,1'b0));
    step("lw_memrd", fe(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));
    step("lw_memwb", fe(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,3'b000,3'b000,1'b0));

    // lw with one wait state in MEMRD.
    step("lw2_fetch", e_fetch);
    step("lw2_decode", e_decode);
    step("lw2_memadr", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b000,1'b0));
    memReady = 1'b0;
    step("lw2_memrd_wait", fe(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));
    memReady = 1'b1;
    step("lw2_memrd", fe(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));
    step("lw2_memwb", fe(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,3'b000,3'b000,1'b0));

    // sw with three wait states in MEMWR.
    op = 7'b0100011;
    step("sw_fetch", e_fetch);
    step("sw_decode", e_decode);
    step("sw_memadr", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b001,1'b0));
    memReady = 1'b0;
    for (int i = 0; i < 3; i++)
      step("sw_memwr_wait", fe(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));
    memReady = 1'b1;
    step("sw_memwr", fe(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));

    // sw aborted by a 2-cycle reset in MEMWR.
    step("swr_fetch", e_fetch);
    step("swr_decode", e_decode);
    step("swr_memadr", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b001,1'b0));
    memReady = 1'b0;
    step("swr_memwr", fe(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0));
    rst = 1'b1;
    #2;
    check("swr_rst_en0", 32'(en), 32'd0);
    @(posedge clk); #1;
    check("swr_rst_en1", 32'(en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; memReady = 1'b1;

    // R-type sub, then the same fields as an I-type add.
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step("swr_after_rst_fetch", e_fetch);
    step("rsub_decode", e_decode);
    step("rsub_exer", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,3'b000,1'b0));
    step("rsub_aluwb", e_aluwb);
    op = 7'b0010011;
    step("iadd_fetch", e_fetch);
    step("iadd_decode", e_decode);
    step("iadd_exei", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b000,1'b0));
    step("iadd_aluwb", e_aluwb);

    itype_alu("slti", 3'b010, 3'b101);
    itype_alu("ori",  3'b110, 3'b011);
    itype_alu("andi", 3'b111, 3'b010);

    // beq taken, bne not taken, both with zero=1.
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    step("beq_fetch", e_fetch);
    step("beq_decode", e_decode);
    step("beq_branch", fe(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,3'b000,1'b0));
    funct3 = 3'b001;
    step("bne_fetch", e_fetch);
    step("bne_decode", e_decode);
    step("bne_branch", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,3'b000,1'b0));
    zero = 1'b0;

    // jal.
    op = 7'b1101111; funct3 = 3'b000;
    step("jal_fetch", e_fetch);
    step("jal_decode", e_decode);
    step("jal_jal", fe(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,3'b100,1'b0));
    step("jal_aluwb", e_aluwb);

    // jalr.
    op = 7'b1100111;
    step("jalr_fetch", e_fetch);
    step("jalr_decode", e_decode);
    step("jalr_jalr", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b000,1'b0));
    step("jalr_jalrpc", fe(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,3'b000,1'b0));
    step("jalr_aluwb", e_aluwb);

    // lui.
    op = 7'b0110111;
    step("lui_fetch", e_fetch);
    step("lui_decode", e_decode);
    step("lui_lui", fe(1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,2'b00,2'b00,3'b000,3'b011,1'b0));

    // Unsupported opcode: one illegalOp pulse, then straight back to FETCH.
    op = 7'b1111111;
    step("ill_fetch", e_fetch);
    step("ill_decode", fe(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b010,1'b1));
    step("ill_after_fetch", e_fetch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
